// File: rtl/div_res_station.sv
// div_res_station: reservation station feeding the DIV/REM unit.
// Define DIV_RS_AGE_ORDER_EN for oldest-first issue select.
module div_res_station #(
  parameter int DEPTH       = 4,
  parameter int NO_PHY_REGS = 64,
  parameter int PHY_WIDTH   = $clog2(NO_PHY_REGS),
  parameter int ROB_WIDTH   = 5,
  parameter int NUM_CDB     = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush,
  input  logic                           dispatch_valid,
  output logic                           dispatch_ready,
  input  logic [2:0]                     dispatch_funct3,
  input  logic [PHY_WIDTH-1:0]           dispatch_ps1,
  input  logic [PHY_WIDTH-1:0]           dispatch_ps2,
  input  logic                           dispatch_ps1_rdy,
  input  logic                           dispatch_ps2_rdy,
  input  logic [PHY_WIDTH-1:0]           dispatch_pd,
  input  logic [ROB_WIDTH-1:0]           dispatch_rob_idx,
  input  logic [NUM_CDB-1:0]             cdb_valid,
  input  logic [NUM_CDB*PHY_WIDTH-1:0]   cdb_pd,
  input  logic                           div_ready,
  output logic                           issue_valid,
  output logic [2:0]                     issue_funct3,
  output logic [PHY_WIDTH-1:0]           issue_ps1,
  output logic [PHY_WIDTH-1:0]           issue_ps2,
  output logic [PHY_WIDTH-1:0]           issue_pd,
  output logic [ROB_WIDTH-1:0]           issue_rob_idx,
  output logic [$clog2(DEPTH):0]         occupancy
);

  localparam int IW = $clog2(DEPTH);
  localparam int OW = IW + 1;

  typedef struct packed {
    logic [2:0]           funct3;
    logic [PHY_WIDTH-1:0] ps1;
    logic [PHY_WIDTH-1:0] ps2;
    logic                 rdy1;
    logic                 rdy2;
    logic [PHY_WIDTH-1:0] pd;
    logic [ROB_WIDTH-1:0] rob_idx;
  } ent_t;

  logic [DEPTH-1:0] valid_q;
  ent_t             ent_q [DEPTH];

  logic [OW-1:0]    occ;
  logic [IW-1:0]    free_idx;
  logic [IW-1:0]    sel_idx;
  logic             any_cand;
  logic [DEPTH-1:0] cand;
  logic [DEPTH-1:0] wake1;
  logic [DEPTH-1:0] wake2;
  logic             disp_fire;
  ent_t             disp_ent;

  function automatic logic cdb_hit(
    input logic [NUM_CDB-1:0]           v,
    input logic [NUM_CDB*PHY_WIDTH-1:0] t,
    input logic [PHY_WIDTH-1:0]         tag
  );
    logic h;
    h = 1'b0;
    for (int k = 0; k < NUM_CDB; k++)
      if (v[k] && t[k*PHY_WIDTH +: PHY_WIDTH] == tag)
        h = 1'b1;
    return h;
  endfunction

  // count live entries from registered valid bits
  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++)
      occ = occ + OW'(valid_q[i]);
  end

  assign occupancy      = occ;
  assign dispatch_ready = (occ < OW'(DEPTH)) && !flush;
  assign disp_fire      = dispatch_valid && dispatch_ready;

  // lowest-index free slot receives the next dispatched op
  always_comb begin
    free_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (!valid_q[i])
        free_idx = IW'(i);
  end

  // CDB snoop for stored entries and for the op being dispatched
  always_comb begin
    wake1 = '0;
    wake2 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      wake1[i] = valid_q[i] && cdb_hit(cdb_valid, cdb_pd, ent_q[i].ps1);
      wake2[i] = valid_q[i] && cdb_hit(cdb_valid, cdb_pd, ent_q[i].ps2);
    end
  end

  // build the entry image written on a dispatch transfer
  always_comb begin
    disp_ent         = '0;
    disp_ent.funct3  = dispatch_funct3;
    disp_ent.ps1     = dispatch_ps1;
    disp_ent.ps2     = dispatch_ps2;
    disp_ent.pd      = dispatch_pd;
    disp_ent.rob_idx = dispatch_rob_idx;
    disp_ent.rdy1    = dispatch_ps1_rdy ||
                       cdb_hit(cdb_valid, cdb_pd, dispatch_ps1);
    disp_ent.rdy2    = dispatch_ps2_rdy ||
                       cdb_hit(cdb_valid, cdb_pd, dispatch_ps2);
  end

  // issue candidates use only registered ready bits
  always_comb begin
    cand = '0;
    for (int i = 0; i < DEPTH; i++)
      cand[i] = valid_q[i] && ent_q[i].rdy1 && ent_q[i].rdy2;
  end

`ifdef DIV_RS_AGE_ORDER_EN
  logic [IW-1:0] age_q [DEPTH];
  logic [IW-1:0] best_age;

  // oldest candidate (smallest rank) wins
  always_comb begin
    sel_idx  = '0;
    any_cand = 1'b0;
    best_age = '1;
    for (int i = 0; i < DEPTH; i++)
      if (cand[i] && (!any_cand || age_q[i] < best_age)) begin
        sel_idx  = IW'(i);
        best_age = age_q[i];
        any_cand = 1'b1;
      end
  end

  // ranks stay a dense 0..occ-1 ordering of live entries
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++)
        age_q[i] <= '0;
    end else if (!flush) begin
      if (issue_valid)
        for (int i = 0; i < DEPTH; i++)
          if (valid_q[i] && age_q[i] > age_q[sel_idx])
            age_q[i] <= age_q[i] - IW'(1);
      if (disp_fire)
        age_q[free_idx] <= IW'(occ - OW'(issue_valid));
    end
  end
`else
  // lowest-index candidate wins
  always_comb begin
    sel_idx  = '0;
    any_cand = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--)
      if (cand[i]) begin
        sel_idx  = IW'(i);
        any_cand = 1'b1;
      end
  end
`endif

  assign issue_valid = any_cand && div_ready && !flush;

  // payload is driven only while an op is actually presented
  always_comb begin
    issue_funct3  = '0;
    issue_ps1     = '0;
    issue_ps2     = '0;
    issue_pd      = '0;
    issue_rob_idx = '0;
    if (issue_valid) begin
      issue_funct3  = ent_q[sel_idx].funct3;
      issue_ps1     = ent_q[sel_idx].ps1;
      issue_ps2     = ent_q[sel_idx].ps2;
      issue_pd      = ent_q[sel_idx].pd;
      issue_rob_idx = ent_q[sel_idx].rob_idx;
    end
  end

  // entry storage: flush beats issue, dispatch and wakeup
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wake1[i]) ent_q[i].rdy1 <= 1'b1;
        if (wake2[i]) ent_q[i].rdy2 <= 1'b1;
      end
      if (issue_valid)
        valid_q[sel_idx] <= 1'b0;
      if (disp_fire) begin
        valid_q[free_idx] <= 1'b1;
        ent_q[free_idx]   <= disp_ent;
      end
    end
  end

endmodule

// File: tb/tb_div_res_station.sv
// tb_div_res_station: directed and random checks of the divide
// reservation station against a slot-level reference model.
module tb_div_res_station;

  localparam int DEPTH = 4;
  localparam int PW    = 6;
  localparam int RW    = 5;
  localparam int NC    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          dispatch_valid;
  logic          dispatch_ready;
  logic [2:0]    dispatch_funct3;
  logic [PW-1:0] dispatch_ps1;
  logic [PW-1:0] dispatch_ps2;
  logic          dispatch_ps1_rdy;
  logic          dispatch_ps2_rdy;
  logic [PW-1:0] dispatch_pd;
  logic [RW-1:0] dispatch_rob_idx;
  logic [NC-1:0] cdb_valid;
  logic [NC*PW-1:0] cdb_pd;
  logic          div_ready;
  logic          issue_valid;
  logic [2:0]    issue_funct3;
  logic [PW-1:0] issue_ps1;
  logic [PW-1:0] issue_ps2;
  logic [PW-1:0] issue_pd;
  logic [RW-1:0] issue_rob_idx;
  logic [2:0]    occupancy;

  always #5 clk = ~clk;

  div_res_station dut (
    .clk              (clk),
    .rst              (rst),
    .flush            (flush),
    .dispatch_valid   (dispatch_valid),
    .dispatch_ready   (dispatch_ready),
    .dispatch_funct3  (dispatch_funct3),
    .dispatch_ps1     (dispatch_ps1),
    .dispatch_ps2     (dispatch_ps2),
    .dispatch_ps1_rdy (dispatch_ps1_rdy),
    .dispatch_ps2_rdy (dispatch_ps2_rdy),
    .dispatch_pd      (dispatch_pd),
    .dispatch_rob_idx (dispatch_rob_idx),
    .cdb_valid        (cdb_valid),
    .cdb_pd           (cdb_pd),
    .div_ready        (div_ready),
    .issue_valid      (issue_valid),
    .issue_funct3     (issue_funct3),
    .issue_ps1        (issue_ps1),
    .issue_ps2        (issue_ps2),
    .issue_pd         (issue_pd),
    .issue_rob_idx    (issue_rob_idx),
    .occupancy        (occupancy)
  );

  int vecs = 0;
  int errs = 0;

  // reference model: one record per slot plus a dispatch sequence
  bit            mv   [DEPTH];
  bit            mr1  [DEPTH];
  bit            mr2  [DEPTH];
  logic [2:0]    mf3  [DEPTH];
  logic [PW-1:0] mps1 [DEPTH];
  logic [PW-1:0] mps2 [DEPTH];
  logic [PW-1:0] mpd  [DEPTH];
  logic [RW-1:0] mrob [DEPTH];
  int            mseq [DEPTH];
  int            seqn = 0;

  int e_occ;
  bit e_dr;
  bit e_iv;
  int e_sel;

  function automatic bit hit(logic [PW-1:0] t);
    for (int k = 0; k < NC; k++)
      if (cdb_valid[k] && cdb_pd[k*PW +: PW] == t)
        return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_eval();
    e_occ = 0;
    e_sel = -1;
    for (int i = 0; i < DEPTH; i++) begin
      if (mv[i]) e_occ++;
      if (mv[i] && mr1[i] && mr2[i]) begin
`ifdef DIV_RS_AGE_ORDER_EN
        if (e_sel < 0 || mseq[i] < mseq[e_sel]) e_sel = i;
`else
        if (e_sel < 0) e_sel = i;
`endif
      end
    end
    e_dr = (e_occ < DEPTH) && !flush;
    e_iv = (e_sel >= 0) && div_ready && !flush;
  endfunction

  task automatic model_step();
    int fr;
    bit dup;
    model_eval();
    if (rst || flush) begin
      for (int i = 0; i < DEPTH; i++) mv[i] = 1'b0;
      return;
    end
    fr  = -1;
    dup = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!mv[i] && fr < 0) fr = i;
      if (mv[i] && mpd[i] == dispatch_pd) dup = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++)
      if (mv[i]) begin
        if (hit(mps1[i])) mr1[i] = 1'b1;
        if (hit(mps2[i])) mr2[i] = 1'b1;
      end
    if (e_iv) mv[e_sel] = 1'b0;
    if (dispatch_valid && e_dr) begin
      assert (!dup) else $error("duplicate pd %0d dispatched", dispatch_pd);
      mv[fr]   = 1'b1;
      mf3[fr]  = dispatch_funct3;
      mps1[fr] = dispatch_ps1;
      mps2[fr] = dispatch_ps2;
      mpd[fr]  = dispatch_pd;
      mrob[fr] = dispatch_rob_idx;
      mr1[fr]  = dispatch_ps1_rdy || hit(dispatch_ps1);
      mr2[fr]  = dispatch_ps2_rdy || hit(dispatch_ps2);
      mseq[fr] = seqn++;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic idle();
    flush            = 1'b0;
    dispatch_valid   = 1'b0;
    dispatch_funct3  = '0;
    dispatch_ps1     = '0;
    dispatch_ps2     = '0;
    dispatch_ps1_rdy = 1'b0;
    dispatch_ps2_rdy = 1'b0;
    dispatch_pd      = '0;
    dispatch_rob_idx = '0;
    cdb_valid        = '0;
    cdb_pd           = '0;
  endtask

  task automatic disp(input logic [2:0] f, input logic [PW-1:0] s1,
                      input bit r1, input logic [PW-1:0] s2,
                      input bit r2, input logic [PW-1:0] d,
                      input logic [RW-1:0] rob);
    dispatch_valid   = 1'b1;
    dispatch_funct3  = f;
    dispatch_ps1     = s1;
    dispatch_ps1_rdy = r1;
    dispatch_ps2     = s2;
    dispatch_ps2_rdy = r2;
    dispatch_pd      = d;
    dispatch_rob_idx = rob;
  endtask

  task automatic test_reset();
    idle();
    div_ready = 1'b1;
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    settle();
    vecs++;
    if (issue_valid !== 1'b0) begin
      errs++; $display("FAIL reset_iv got %b want 0", issue_valid);
    end
    vecs++;
    if (dispatch_ready !== 1'b1) begin
      errs++; $display("FAIL reset_dr got %b want 1", dispatch_ready);
    end
    vecs++;
    if (occupancy !== 3'd0) begin
      errs++; $display("FAIL reset_occ got %0d want 0", occupancy);
    end
    vecs++;
    if ({issue_funct3, issue_ps1, issue_ps2, issue_pd, issue_rob_idx} !== '0) begin
      errs++; $display("FAIL reset_payload got pd=%0d want 0", issue_pd);
    end
  endtask

  task automatic test_basic();
    disp(3'b100, 6'd5, 1, 6'd7, 1, 6'd9, 5'd3);
    settle();
    vecs++;
    if (issue_valid !== 1'b0) begin
      errs++; $display("FAIL basic_iv0 got %b want 0", issue_valid);
    end
    cyc();
    idle();
    settle();
    vecs++;
    if ({issue_valid, issue_funct3, issue_ps1, issue_ps2, issue_pd, issue_rob_idx}
        !== {1'b1, 3'b100, 6'd5, 6'd7, 6'd9, 5'd3}) begin
      errs++;
      $display("FAIL basic_issue got v=%b f=%0d ps1=%0d ps2=%0d pd=%0d rob=%0d want 1/4/5/7/9/3",
               issue_valid, issue_funct3, issue_ps1, issue_ps2, issue_pd, issue_rob_idx);
    end
    cyc();
    settle();
    vecs++;
    if (occupancy !== 3'd0) begin
      errs++; $display("FAIL basic_occ got %0d want 0", occupancy);
    end
  endtask

  task automatic test_cdb_wakeup();
    disp(3'b101, 6'd3, 1, 6'd12, 0, 6'd13, 5'd4);
    settle();
    cyc();
    idle();
    settle();
    vecs++;
    if (issue_valid !== 1'b0) begin
      errs++; $display("FAIL wake_wait got %b want 0", issue_valid);
    end
    cyc();
    cdb_valid = 2'b01;
    cdb_pd    = {6'd0, 6'd12};
    settle();
    vecs++;
    if (issue_valid !== 1'b0) begin
      errs++; $display("FAIL wake_bcast_cycle got %b want 0", issue_valid);
    end
    cyc();
    idle();
    settle();
    vecs++;
    if (issue_valid !== 1'b1 || issue_pd !== 6'd13) begin
      errs++;
      $display("FAIL wake_issue got v=%b pd=%0d want 1/13", issue_valid, issue_pd);
    end
    cyc();
  endtask

  task automatic test_dispatch_wakeup();
    disp(3'b110, 6'd20, 0, 6'd0, 1, 6'd21, 5'd5);
    cdb_valid = 2'b10;
    cdb_pd    = {6'd20, 6'd0};
    settle();
    cyc();
    idle();
    settle();
    vecs++;
    if (issue_valid !== 1'b1 || issue_pd !== 6'd21 || issue_ps1 !== 6'd20) begin
      errs++;
      $display("FAIL dwake_issue got v=%b pd=%0d ps1=%0d want 1/21/20",
               issue_valid, issue_pd, issue_ps1);
    end
    cyc();
    settle();
    vecs++;
    if (occupancy !== 3'd0) begin
      errs++; $display("FAIL dwake_occ got %0d want 0", occupancy);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      disp(3'b111, PW'(30 + i), 0, 6'd0, 1, PW'(40 + i), RW'(i));
      settle();
      vecs++;
      if (dispatch_ready !== 1'b1) begin
        errs++; $display("FAIL fill_dr%0d got %b want 1", i, dispatch_ready);
      end
      cyc();
    end
    disp(3'b100, 6'd0, 1, 6'd0, 1, 6'd50, 5'd9);
    settle();
    vecs++;
    if (dispatch_ready !== 1'b0 || occupancy !== 3'd4) begin
      errs++;
      $display("FAIL full_state got dr=%b occ=%0d want 0/4", dispatch_ready, occupancy);
    end
    cyc();
    idle();
    cdb_valid = 2'b01;
    cdb_pd    = {6'd0, 6'd32};
    settle();
    vecs++;
    if (occupancy !== 3'd4 || issue_valid !== 1'b0) begin
      errs++;
      $display("FAIL full_drop got occ=%0d iv=%b want 4/0", occupancy, issue_valid);
    end
    cyc();
    idle();
    settle();
    vecs++;
    if (issue_valid !== 1'b1 || issue_pd !== 6'd42 || dispatch_ready !== 1'b0) begin
      errs++;
      $display("FAIL full_issue got v=%b pd=%0d dr=%b want 1/42/0",
               issue_valid, issue_pd, dispatch_ready);
    end
    cyc();
    settle();
    vecs++;
    if (dispatch_ready !== 1'b1 || occupancy !== 3'd3) begin
      errs++;
      $display("FAIL full_free got dr=%b occ=%0d want 1/3", dispatch_ready, occupancy);
    end
    flush = 1'b1;
    cyc();
    idle();
  endtask

  task automatic test_stall();
    div_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(3'b100, 6'd1, 1, 6'd2, 1, PW'(51 + i), RW'(i));
      settle();
      cyc();
    end
    idle();
    for (int c = 0; c < 5; c++) begin
      settle();
      vecs++;
      if (issue_valid !== 1'b0 || occupancy !== 3'd3) begin
        errs++;
        $display("FAIL stall_hold%0d got iv=%b occ=%0d want 0/3",
                 c, issue_valid, occupancy);
      end
      cyc();
    end
    div_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      vecs++;
      if (issue_valid !== 1'b1 || issue_pd !== PW'(51 + i)) begin
        errs++;
        $display("FAIL stall_release%0d got v=%b pd=%0d want 1/%0d",
                 i, issue_valid, issue_pd, 51 + i);
      end
      cyc();
    end
    settle();
    vecs++;
    if (occupancy !== 3'd0) begin
      errs++; $display("FAIL stall_occ got %0d want 0", occupancy);
    end
  endtask

  task automatic test_flush();
    div_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      disp(3'b101, 6'd1, 1, 6'd2, 1, PW'(54 + i), RW'(i));
      settle();
      cyc();
    end
    div_ready = 1'b1;
    disp(3'b100, 6'd1, 1, 6'd2, 1, 6'd57, 5'd7);
    flush = 1'b1;
    settle();
    vecs++;
    if (issue_valid !== 1'b0 || dispatch_ready !== 1'b0) begin
      errs++;
      $display("FAIL flush_cycle got iv=%b dr=%b want 0/0", issue_valid, dispatch_ready);
    end
    cyc();
    idle();
    settle();
    vecs++;
    if (occupancy !== 3'd0 || issue_valid !== 1'b0) begin
      errs++;
      $display("FAIL flush_after got occ=%0d iv=%b want 0/0", occupancy, issue_valid);
    end
  endtask

  task automatic test_age();
    logic [PW-1:0] first;
    logic [PW-1:0] second;
`ifdef DIV_RS_AGE_ORDER_EN
    first  = 6'd12;
    second = 6'd14;
`else
    first  = 6'd14;
    second = 6'd12;
`endif
    div_ready = 1'b1;
    disp(3'b100, 6'd40, 0, 6'd0, 1, 6'd10, 5'd0);
    settle(); cyc();
    disp(3'b100, 6'd41, 0, 6'd0, 1, 6'd11, 5'd1);
    settle(); cyc();
    disp(3'b100, 6'd42, 0, 6'd0, 1, 6'd12, 5'd2);
    settle(); cyc();
    idle();
    cdb_valid = 2'b01;
    cdb_pd    = {6'd0, 6'd40};
    settle(); cyc();
    idle();
    settle();
    vecs++;
    if (issue_valid !== 1'b1 || issue_pd !== 6'd10) begin
      errs++;
      $display("FAIL age_x got v=%b pd=%0d want 1/10", issue_valid, issue_pd);
    end
    cyc();
    disp(3'b100, 6'd43, 0, 6'd0, 1, 6'd14, 5'd4);
    settle(); cyc();
    idle();
    cdb_valid = 2'b11;
    cdb_pd    = {6'd43, 6'd42};
    settle(); cyc();
    idle();
    settle();
    vecs++;
    if (issue_valid !== 1'b1 || issue_pd !== first) begin
      errs++;
      $display("FAIL age_first got v=%b pd=%0d want 1/%0d", issue_valid, issue_pd, first);
    end
    cyc();
    settle();
    vecs++;
    if (issue_valid !== 1'b1 || issue_pd !== second) begin
      errs++;
      $display("FAIL age_second got v=%b pd=%0d want 1/%0d", issue_valid, issue_pd, second);
    end
    cyc();
    flush = 1'b1;
    cyc();
    idle();
  endtask

  task automatic test_random();
    logic [PW-1:0] d;
    bit ok;
    for (int c = 0; c < 2000; c++) begin
      idle();
      flush     = ($urandom_range(39) == 0);
      div_ready = ($urandom_range(9) < 7);
      if ($urandom_range(9) < 6) begin
        ok = 1'b0;
        d  = '0;
        while (!ok) begin
          d  = PW'($urandom_range(63, 1));
          ok = 1'b1;
          for (int i = 0; i < DEPTH; i++)
            if (mv[i] && mpd[i] == d) ok = 1'b0;
        end
        disp(3'($urandom_range(7, 4)), PW'($urandom_range(15)),
             ($urandom_range(9) < 3), PW'($urandom_range(15)),
             ($urandom_range(9) < 3), d, RW'($urandom));
        if (dispatch_ps1 == '0) dispatch_ps1_rdy = 1'b1;
        if (dispatch_ps2 == '0) dispatch_ps2_rdy = 1'b1;
      end
      for (int k = 0; k < NC; k++) begin
        cdb_valid[k]          = $urandom_range(1);
        cdb_pd[k*PW +: PW]    = PW'($urandom_range(15, 1));
      end
      settle();
      vecs++;
      if (dispatch_ready !== e_dr || occupancy !== 3'(e_occ)) begin
        errs++;
        $display("FAIL rnd_dr_occ c=%0d got dr=%b occ=%0d want %b/%0d",
                 c, dispatch_ready, occupancy, e_dr, e_occ);
      end
      vecs++;
      if (issue_valid !== e_iv) begin
        errs++;
        $display("FAIL rnd_iv c=%0d got %b want %b", c, issue_valid, e_iv);
      end else if (e_iv) begin
        vecs++;
        if ({issue_funct3, issue_ps1, issue_ps2, issue_pd, issue_rob_idx} !==
            {mf3[e_sel], mps1[e_sel], mps2[e_sel], mpd[e_sel], mrob[e_sel]}) begin
          errs++;
          $display("FAIL rnd_payload c=%0d got pd=%0d rob=%0d want pd=%0d rob=%0d",
                   c, issue_pd, issue_rob_idx, mpd[e_sel], mrob[e_sel]);
        end
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_cdb_wakeup();
    test_dispatch_wakeup();
    test_full();
    test_stall();
    test_flush();
    test_age();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
